// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the XOR stream cipher core.
package xor_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_LEN  = 3'd1,
    GET_KLEN = 3'd2,
    GET_KEY  = 3'd3,
    GET_DATA = 3'd4,
    ENCRYPT  = 3'd5,
    SEND     = 3'd6
  } state_t;

  localparam int MODE_CHAIN   = 0;
  localparam int MODE_DECRYPT = 1;

  function automatic logic [7:0] cipherByte(input logic [7:0] d, input logic [7:0] k,
                                            input logic [7:0] prev, input logic chain);
    return d ^ k ^ (chain ? prev : 8'h00);
  endfunction

endpackage

// File: rtl/xor_cipher_tx_ctrl.sv
// Streams the result buffer to the UART sender, one byte per send/busy handshake.
module xor_cipher_tx_ctrl #(
  parameter int IW = 7
) (
  input  logic          Clk_100M,
  input  logic          Reset,
  input  logic          start,
  input  logic [7:0]    len,
  input  logic [7:0]    byteIn,
  input  logic          tx_busy,
  output logic [IW-1:0] index,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  output logic          fin
);

  logic       active_r;
  logic       send_r;
  logic       fin_r;
  logic [7:0] idx_r;
  logic [7:0] data_r;

  // Issue a byte when the sender is idle; retire it once busy is observed.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      active_r <= 1'b0;
      send_r   <= 1'b0;
      fin_r    <= 1'b0;
      idx_r    <= 8'd0;
      data_r   <= 8'd0;
    end else begin
      fin_r <= 1'b0;
      if (start) begin
        active_r <= 1'b1;
        send_r   <= 1'b0;
        idx_r    <= 8'd0;
      end else if (active_r) begin
        if (send_r) begin
          if (tx_busy) begin
            send_r <= 1'b0;
            if (idx_r == len - 8'd1) begin
              active_r <= 1'b0;
              fin_r    <= 1'b1;
            end else begin
              idx_r <= idx_r + 8'd1;
            end
          end
        end else if (!tx_busy) begin
          send_r <= 1'b1;
          data_r <= byteIn;
        end
      end
    end
  end

  assign index   = idx_r[IW-1:0];
  assign tx_data = data_r;
  assign tx_send = send_r;
  assign fin     = fin_r;

endmodule

// File: rtl/xor_stream_cipher.sv
// Framed byte-stream XOR cipher between UART receiver and sender, with
// optional chaining and display read-back of the input and result buffers.
module xor_stream_cipher import xor_cipher_pkg::*; #(
  parameter int         MAX_DATA = 100,
  parameter int         MAX_KEY  = 8,
  parameter logic [7:0] IV       = 8'h00
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ack,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic [7:0] view_index,
  output logic [7:0] view_in,
  output logic [7:0] view_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int         DW         = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
  localparam int         KW         = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
  localparam logic [7:0] MAX_DATA_B = 8'(MAX_DATA);
  localparam logic [7:0] MAX_KEY_B  = 8'(MAX_KEY);

  state_t        state_r;
  logic [1:0]    mode_r;
  logic [7:0]    dataLen_r;
  logic [7:0]    keyLen_r;
  logic [7:0]    idx_r;
  logic [7:0]    keyIdx_r;
  logic [7:0]    prev_r;
  logic          rxAck_r;
  logic          err_r;
  logic [7:0]    dataBuf   [MAX_DATA];
  logic [7:0]    resultBuf [MAX_DATA];
  logic [7:0]    keyBuf    [MAX_KEY];

  logic          rxTake_s;
  logic          lastData_s;
  logic          txStart_s;
  logic          txFin_s;
  logic [DW-1:0] txIdx_s;
  logic [7:0]    curData_s;
  logic [7:0]    encByte_s;

  assign rxTake_s   = rx_ready & ~rxAck_r;
  assign lastData_s = (idx_r == dataLen_r - 8'd1);
  assign txStart_s  = (state_r == ENCRYPT) & lastData_s;
  assign curData_s  = dataBuf[idx_r[DW-1:0]];
  assign encByte_s  = cipherByte(curData_s, keyBuf[keyIdx_r[KW-1:0]], prev_r, mode_r[MODE_CHAIN]);

  // Buffer storage; contents survive a finished frame for the display.
  always_ff @(posedge Clk_100M) begin
    if (rxTake_s && state_r == GET_KEY) keyBuf[idx_r[KW-1:0]] <= rx_data;
    if (rxTake_s && state_r == GET_DATA) dataBuf[idx_r[DW-1:0]] <= rx_data;
    if (state_r == ENCRYPT) resultBuf[idx_r[DW-1:0]] <= encByte_s;
  end

  // Frame parser, cipher sequencing and receive handshake.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state_r   <= IDLE;
      mode_r    <= 2'd0;
      dataLen_r <= 8'd0;
      keyLen_r  <= 8'd0;
      idx_r     <= 8'd0;
      keyIdx_r  <= 8'd0;
      prev_r    <= 8'd0;
      rxAck_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (rxTake_s) rxAck_r <= 1'b1;
      else if (!rx_ready) rxAck_r <= 1'b0;

      case (state_r)
        IDLE: if (rxTake_s) begin
          if (rx_data[7:2] != 6'd0) begin
            err_r <= 1'b1;
          end else begin
            err_r   <= 1'b0;
            mode_r  <= rx_data[1:0];
            state_r <= GET_LEN;
          end
        end
        GET_LEN: if (rxTake_s) begin
          if (rx_data == 8'd0 || rx_data > MAX_DATA_B) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            dataLen_r <= rx_data;
            state_r   <= GET_KLEN;
          end
        end
        GET_KLEN: if (rxTake_s) begin
          if (rx_data == 8'd0 || rx_data > MAX_KEY_B) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            keyLen_r <= rx_data;
            idx_r    <= 8'd0;
            state_r  <= GET_KEY;
          end
        end
        GET_KEY: if (rxTake_s) begin
          if (idx_r == keyLen_r - 8'd1) begin
            idx_r   <= 8'd0;
            state_r <= GET_DATA;
          end else begin
            idx_r <= idx_r + 8'd1;
          end
        end
        GET_DATA: if (rxTake_s) begin
          if (lastData_s) begin
            idx_r    <= 8'd0;
            keyIdx_r <= 8'd0;
            prev_r   <= IV;
            state_r  <= ENCRYPT;
          end else begin
            idx_r <= idx_r + 8'd1;
          end
        end
        ENCRYPT: begin
          // Chained decrypt feeds back the ciphertext input, encrypt the output.
          prev_r   <= mode_r[MODE_DECRYPT] ? curData_s : encByte_s;
          keyIdx_r <= (keyIdx_r == keyLen_r - 8'd1) ? 8'd0 : keyIdx_r + 8'd1;
          if (lastData_s) begin
            idx_r   <= 8'd0;
            state_r <= SEND;
          end else begin
            idx_r <= idx_r + 8'd1;
          end
        end
        SEND: if (txFin_s) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  xor_cipher_tx_ctrl #(.IW(DW)) uTxCtrl (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .start    (txStart_s),
    .len      (dataLen_r),
    .byteIn   (resultBuf[txIdx_s]),
    .tx_busy  (tx_busy),
    .index    (txIdx_s),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .fin      (txFin_s)
  );

  assign view_in  = (view_index < dataLen_r) ? dataBuf[view_index[DW-1:0]] : 8'h00;
  assign view_out = (view_index < dataLen_r) ? resultBuf[view_index[DW-1:0]] : 8'h00;
  assign rx_ack   = rxAck_r;
  assign busy     = (state_r != IDLE);
  assign done     = txFin_s;
  assign err      = err_r;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench: vector table, hand-written corner sequences and randomized frames.
module tb_xor_stream_cipher;

  localparam int         MAX_DATA = 100;
  localparam int         MAX_KEY  = 8;
  localparam logic [7:0] IV       = 8'h00;

  logic       Clk_100M = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [7:0] view_index = 8'h00;
  logic [7:0] view_in;
  logic [7:0] view_out;
  logic       busy;
  logic       done;
  logic       err;

  always #5 Clk_100M = ~Clk_100M;

  xor_stream_cipher #(.MAX_DATA(MAX_DATA), .MAX_KEY(MAX_KEY), .IV(IV)) dut (
    .Clk_100M(Clk_100M), .Reset(Reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ack(rx_ack), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .view_index(view_index), .view_in(view_in), .view_out(view_out),
    .busy(busy), .done(done), .err(err)
  );

  int         tests = 0;
  int         fails = 0;
  int         busyCycles = 2;
  int         busyDelay = 0;
  int         doneCnt = 0;
  int         unstable = 0;
  bit         prevSend = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] txQ[$];
  logic [7:0] expQ[$];
  logic [7:0] keyQ[$];
  logic [7:0] datQ[$];

  typedef struct {
    int          n;
    logic [95:0] frm;
    int          ne;
    logic [31:0] ex;
    logic        er;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, expected event within bound", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk_100M);
    #1;
  endtask

  // UART sender model: latch on tx_send, optionally delay busy, then stay busy.
  initial begin
    forever begin
      @(negedge Clk_100M);
      if (tx_send === 1'b1 && !tx_busy) begin
        txQ.push_back(tx_data);
        repeat (busyDelay) begin
          @(negedge Clk_100M);
          if (tx_send !== 1'b1) unstable++;
        end
        tx_busy = 1'b1;
        repeat (busyCycles) @(negedge Clk_100M);
        tx_busy = 1'b0;
      end
    end
  end

  always @(negedge Clk_100M) begin
    if (tx_send === 1'b1 && prevSend && tx_data !== prevData) unstable++;
    prevSend = (tx_send === 1'b1);
    prevData = tx_data;
    if (done === 1'b1) doneCnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic sendByte(input logic [7:0] b, input int hold);
    int t;
    rx_data  = b;
    rx_ready = 1'b1;
    t = 0;
    while (rx_ack !== 1'b1 && t < 200) begin tick(1); t++; end
    if (t >= 200) timeoutFail("rx_ack rise");
    tick(hold);
    rx_ready = 1'b0;
    t = 0;
    while (rx_ack !== 1'b0 && t < 200) begin tick(1); t++; end
    if (t >= 200) timeoutFail("rx_ack fall");
  endtask

  task automatic sendQueues(input logic [1:0] mode, input int hold);
    sendByte({6'd0, mode}, hold);
    sendByte(8'(datQ.size()), hold);
    sendByte(8'(keyQ.size()), hold);
    foreach (keyQ[i]) sendByte(keyQ[i], hold);
    foreach (datQ[i]) sendByte(datQ[i], hold);
  endtask

  // Reference: repeating key, chaining value starts at IV and follows
  // the ciphertext (output when encrypting, input when decrypting).
  function automatic void buildExpected(input logic [1:0] mode);
    logic [7:0] prev;
    logic [7:0] r;
    prev = IV;
    expQ.delete();
    foreach (datQ[i]) begin
      r = datQ[i] ^ keyQ[i % keyQ.size()];
      if (mode[0]) r = r ^ prev;
      expQ.push_back(r);
      prev = mode[1] ? datQ[i] : r;
    end
  endfunction

  task automatic finishFrame(input string name, input logic expErr);
    int t;
    t = 0;
    if (expQ.size() > 0) begin
      while (doneCnt == 0 && t < 5000) begin tick(1); t++; end
      if (doneCnt == 0) timeoutFail({name, " done"});
    end
    tick(6);
    check({name, " err"}, 32'(err), 32'(expErr));
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " tx count"}, txQ.size(), expQ.size());
    check({name, " done count"}, doneCnt, (expQ.size() > 0) ? 32'd1 : 32'd0);
    check({name, " tx stable"}, unstable, 32'd0);
    foreach (expQ[i])
      if (i < txQ.size()) check($sformatf("%s byte%0d", name, i), 32'(txQ[i]), 32'(expQ[i]));
    txQ.delete();
    doneCnt  = 0;
    unstable = 0;
  endtask

  task automatic loadVec(input int v);
    expQ.delete();
    for (int j = 0; j < vecs[v].ne; j++) expQ.push_back(vecs[v].ex[8*(vecs[v].ne-1-j) +: 8]);
  endtask

  task automatic sendVec(input int v, input int hold);
    for (int j = 0; j < vecs[v].n; j++) sendByte(vecs[v].frm[8*(vecs[v].n-1-j) +: 8], hold);
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, " rx_ack"}, 32'(rx_ack), 32'd0);
    check({name, " tx_send"}, 32'(tx_send), 32'd0);
    check({name, " tx_data"}, 32'(tx_data), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " err"}, 32'(err), 32'd0);
    check({name, " view_in"}, 32'(view_in), 32'd0);
    check({name, " view_out"}, 32'(view_out), 32'd0);
  endtask

  initial begin
    logic [1:0] mode;
    int         dlen;
    int         klen;

    vecs[0] = '{8, 96'({8'h00, 8'h03, 8'h02, 8'h0F, 8'hF0, 8'h41, 8'h42, 8'h43}), 3, 32'({8'h4E, 8'hB2, 8'h4C}), 1'b0};
    vecs[1] = '{7, 96'({8'h01, 8'h03, 8'h01, 8'h55, 8'h10, 8'h20, 8'h30}), 3, 32'({8'h45, 8'h30, 8'h55}), 1'b0};
    vecs[2] = '{7, 96'({8'h03, 8'h03, 8'h01, 8'h55, 8'h45, 8'h30, 8'h55}), 3, 32'({8'h10, 8'h20, 8'h30}), 1'b0};
    vecs[3] = '{2, 96'({8'h00, 8'h00}), 0, 32'h0, 1'b1};
    vecs[4] = '{5, 96'({8'h00, 8'h01, 8'h01, 8'hFF, 8'h00}), 1, 32'({8'hFF}), 1'b0};
    vecs[5] = '{3, 96'({8'h00, 8'h01, 8'h09}), 0, 32'h0, 1'b1};
    vecs[6] = '{1, 96'({8'h04}), 0, 32'h0, 1'b1};
    vecs[7] = '{2, 96'({8'h00, 8'h65}), 0, 32'h0, 1'b1};
    vecs[8] = '{9, 96'({8'h00, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB}), 2, 32'({8'hBB, 8'h99}), 1'b0};
    vecs[9] = '{6, 96'({8'h02, 8'h02, 8'h01, 8'h0F, 8'hF0, 8'h0F}), 2, 32'({8'hFF, 8'h00}), 1'b0};

    tick(3);
    checkResetOutputs("reset");
    Reset = 1'b0;
    tick(2);

    for (int v = 0; v < 10; v++) begin
      loadVec(v);
      sendVec(v, 0);
      finishFrame($sformatf("vec%0d", v), vecs[v].er);
    end

    // Slow sender: busy asserted late and held for 50 cycles per byte.
    busyCycles = 50;
    busyDelay  = 3;
    loadVec(0);
    sendVec(0, 0);
    finishFrame("busyhold", 1'b0);
    busyCycles = 2;
    busyDelay  = 0;

    view_index = 8'd2; #1;
    check("view_in idx2", 32'(view_in), 32'h43);
    check("view_out idx2", 32'(view_out), 32'h4C);
    view_index = 8'd0; #1;
    check("view_in idx0", 32'(view_in), 32'h41);
    check("view_out idx0", 32'(view_out), 32'h4E);
    view_index = 8'd5; #1;
    check("view_in idx5", 32'(view_in), 32'h00);
    check("view_out idx5", 32'(view_out), 32'h00);
    view_index = 8'd0;

    loadVec(0);
    sendVec(0, 20);
    finishFrame("rxhold", 1'b0);

    // Reset in the middle of GET_DATA aborts the frame without Tx.
    sendByte(8'h00, 0); sendByte(8'h03, 0); sendByte(8'h01, 0);
    sendByte(8'h55, 0); sendByte(8'h10, 0);
    Reset = 1'b1;
    tick(1);
    checkResetOutputs("midreset");
    tick(1);
    Reset = 1'b0;
    tick(30);
    check("midreset no tx", txQ.size(), 32'd0);
    loadVec(0);
    sendVec(0, 0);
    finishFrame("after reset", 1'b0);

    sendByte(8'h04, 0);
    check("err set", 32'(err), 32'd1);
    Reset = 1'b1;
    tick(2);
    check("err reset", 32'(err), 32'd0);
    Reset = 1'b0;
    tick(2);

    keyQ.delete(); datQ.delete();
    keyQ.push_back(8'($urandom));
    for (int i = 0; i < MAX_DATA; i++) datQ.push_back(8'($urandom));
    mode = 2'($urandom_range(0, 3));
    buildExpected(mode);
    sendQueues(mode, 0);
    finishFrame("maxdata", 1'b0);

    for (int f = 0; f < 8; f++) begin
      keyQ.delete(); datQ.delete();
      mode = 2'($urandom_range(0, 3));
      dlen = $urandom_range(1, 16);
      klen = $urandom_range(1, MAX_KEY);
      for (int i = 0; i < klen; i++) keyQ.push_back(8'($urandom));
      for (int i = 0; i < dlen; i++) datQ.push_back(8'($urandom));
      buildExpected(mode);
      sendQueues(mode, $urandom_range(0, 3));
      finishFrame($sformatf("rand%0d", f), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
